bit_phase_sequencer: RTL and testbench
======================================

Name: bit_phase_sequencer

Overview:
Parametrised bit-serial sequencer: steps a bit index across a WIDTH-bit word for each of up to PHASES datapath phases (e.g. fetch/decode/execute/writeback).
- Generalises the fixed 3-bit bit counter with configurable word width, multiple phases, per-word phase skipping, LSB/MSB-first ordering, stall, abort and a start/ready handshake.
- Sits between the control FSM and the serial ALU/register-file shifters.

Parameters:
WIDTH, 8, bits per word per phase; must be >= 2.
PHASES, 4, number of phases per word; must be >= 1.
CW, $clog2(WIDTH), bit index width (derived; do not override).
PW, max(1,$clog2(PHASES)), phase index width (derived).

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, asynchronous, active-low.
start  in  1  request a new word; accepted only when ready=1.
stall  in  1  freeze sequencing for this cycle (RUN only).
abort  in  1  synchronous cancel; highest priority after reset.
msb_first  in  1  bit order for the word; sampled at accept.
phase_mask  in  PHASES  1=execute phase, 0=skip; sampled at accept.
ready  out  1  high in IDLE.
busy  out  1  high in RUN.
bit_idx  out  CW  current bit position.
phase  out  PW  current phase index.
bit_valid  out  1  a bit is processed this cycle.
first_bit  out  1  bit_valid and cnt==0.
last_bit  out  1  bit_valid and cnt==WIDTH-1.
phase_done  out  1  one-cycle pulse, cycle after a phase's last bit.
word_done  out  1  one-cycle pulse, word complete.

Behaviour:
- States: IDLE, RUN. Internal cnt (CW bits), phase reg, latched msb_first_l, mask_l.
- Reset (async, rstn=0): IDLE, cnt=0, phase=0, mask_l=0, msb_first_l=0; phase_done=word_done=0; ready=1, busy=0, bit_valid/first_bit/last_bit=0, bit_idx=0.
- IDLE: ready=1, bit_valid=0, bit_idx=0, phase=0; stall ignored.
- Accept: start=1, abort=0 in IDLE -> latch msb_first and phase_mask; cnt=0; phase = lowest set bit of phase_mask; -> RUN. First bit_valid is the cycle after accept.
- Empty mask accept (phase_mask=0): stay IDLE; word_done pulses next cycle; busy never asserts.
- RUN: bit_valid = !stall; bit_idx = msb_first_l ? WIDTH-1-cnt : cnt (combinational from cnt). first_bit/last_bit are combinational, gated by bit_valid.
- Edge in RUN with !stall and cnt<WIDTH-1: cnt+1.
- Edge in RUN with !stall and cnt==WIDTH-1: cnt=0; phase_done=1 next cycle. If a higher set bit exists in mask_l, phase = next higher set bit and stay in RUN (no gap cycle). Otherwise -> IDLE, phase=0, word_done=1 next cycle (coincides with phase_done).
- Stall in RUN: cnt and phase hold; no pulses generated.
- start while in RUN: ignored. start in the word_done/ready cycle: accepted (back-to-back, no bubble).
- abort=1 in any state: next edge -> IDLE, cnt=0, phase=0; phase_done/word_done forced 0 next cycle; overrides start and stall.
- Word length: WIDTH*popcount(mask) bit_valid cycles plus stall cycles.
- cnt never exceeds WIDTH-1, including non-power-of-2 WIDTH; wrap is explicit at WIDTH-1.
- phase_done/word_done are registered and last exactly one cycle.

Test Plan:
- Async reset mid-RUN (WIDTH=8, phase 2, cnt 4): drop rstn between edges -> busy=0, bit_valid=0, bit_idx=0, phase=0 immediately; ready=1.
- WIDTH=8, PHASES=4, mask=4'b1111, msb_first=0, start -> 32 consecutive bit_valid cycles, bit_idx 0..7 per phase, phase 0,1,2,3. phase_done pulses 4 times; word_done at cycle 33 after accept together with the final phase_done.
- mask=4'b0101, msb_first=1 -> 16 bit_valid cycles, phase 0 then 2, bit_idx 7..0 each; first_bit at idx 7, last_bit at idx 0.
- mask=4'b1111, stall=1 for 3 cycles at phase 1 cnt 5 -> bit_idx holds 5, bit_valid=0 for 3 cycles; word_done at cycle 36.
- abort at phase 2 cnt 3 -> IDLE next cycle, no phase_done/word_done. Then mask=0 start -> word_done pulse next cycle, busy stays 0.
- WIDTH=5, PHASES=3, mask=3'b111: start asserted again in the word_done cycle -> new word starts with no bubble; cnt wraps 4->0 and never reaches 5–7.

Source files
------------

// File: rtl/bit_phase_sequencer.sv
// Bit-serial sequencer: walks a bit index across WIDTH bits for each enabled phase of a word.
// Latency: first bit_valid the cycle after accept; phase_done/word_done are registered 1-cycle pulses.
// Backpressure: stall_i freezes cnt/phase in RUN; start_i is only taken when ready_o is high.
module bit_phase_sequencer #(
  parameter int WIDTH  = 8,
  parameter int PHASES = 4,
  localparam int CW    = $clog2(WIDTH),
  localparam int PW    = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              abort_i,
  input  logic              msb_first_i,
  input  logic [PHASES-1:0] phase_mask_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [CW-1:0]     bit_idx_o,
  output logic [PW-1:0]     phase_o,
  output logic              bit_valid_o,
  output logic              first_bit_o,
  output logic              last_bit_o,
  output logic              phase_done_o,
  output logic              word_done_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  // Explicit wrap point so non-power-of-2 widths never run past WIDTH-1.
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     phase_q;
  logic              msb_first_q;
  logic [PHASES-1:0] mask_q;
  logic              phase_done_q;
  logic              word_done_q;

  logic [PW-1:0]     first_phase_d;
  logic              first_found;
  logic [PW-1:0]     next_phase_d;
  logic              next_found;

  // Lowest enabled phase of the incoming mask; no match means an empty word.
  always_comb begin
    first_phase_d = '0;
    first_found   = 1'b0;
    for (int p = 0; p < PHASES; p++) begin
      if (!first_found && phase_mask_i[p]) begin
        first_phase_d = PW'(p);
        first_found   = 1'b1;
      end
    end
  end

  // Next enabled phase above the current one; no match means this is the last phase.
  always_comb begin
    next_phase_d = '0;
    next_found   = 1'b0;
    for (int p = 0; p < PHASES; p++) begin
      if (!next_found && mask_q[p] && (p > int'(phase_q))) begin
        next_phase_d = PW'(p);
        next_found   = 1'b1;
      end
    end
  end

  // Control FSM: accept, bit stepping, phase advance, abort; pulses default low each cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      msb_first_q  <= 1'b0;
      mask_q       <= '0;
      phase_done_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      phase_done_q <= 1'b0;
      word_done_q  <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        phase_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              msb_first_q <= msb_first_i;
              mask_q      <= phase_mask_i;
              cnt_q       <= '0;
              if (first_found) begin
                phase_q <= first_phase_d;
                state_q <= S_RUN;
              end else begin
                // Empty word: complete immediately without ever going busy.
                phase_q     <= '0;
                word_done_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (!stall_i) begin
              if (cnt_q == CNT_MAX) begin
                cnt_q        <= '0;
                phase_done_q <= 1'b1;
                if (next_found) begin
                  phase_q <= next_phase_d;
                end else begin
                  phase_q     <= '0;
                  state_q     <= S_IDLE;
                  word_done_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Output decode: status from state, bit strobes follow stall combinationally.
  always_comb begin
    ready_o      = (state_q == S_IDLE);
    busy_o       = (state_q == S_RUN);
    bit_valid_o  = busy_o && !stall_i;
    bit_idx_o    = '0;
    if (busy_o) begin
      bit_idx_o = msb_first_q ? (CNT_MAX - cnt_q) : cnt_q;
    end
    phase_o      = phase_q;
    first_bit_o  = bit_valid_o && (cnt_q == '0);
    last_bit_o   = bit_valid_o && (cnt_q == CNT_MAX);
    phase_done_o = phase_done_q;
    word_done_o  = word_done_q;
  end

endmodule

// File: tb/tb_bit_phase_sequencer.sv
// Bench for bit_phase_sequencer: two instances (8x4 and 5x3) driven from a per-cycle scoreboard.
// Each record holds the inputs for one cycle and the outputs expected in that same cycle.
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
module tb_bit_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, stall, abort, msb_first, start_a, start_b;
  logic [3:0] mask_a;
  logic [2:0] mask_b;

  logic       ready_a, busy_a, bv_a, fb_a, lb_a, pd_a, wd_a;
  logic [2:0] idx_a;
  logic [1:0] ph_a;
  logic       ready_b, busy_b, bv_b, fb_b, lb_b, pd_b, wd_b;
  logic [2:0] idx_b;
  logic [1:0] ph_b;

  bit_phase_sequencer #(.WIDTH(8), .PHASES(4)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .stall_i(stall), .abort_i(abort),
    .msb_first_i(msb_first), .phase_mask_i(mask_a), .ready_o(ready_a), .busy_o(busy_a),
    .bit_idx_o(idx_a), .phase_o(ph_a), .bit_valid_o(bv_a), .first_bit_o(fb_a),
    .last_bit_o(lb_a), .phase_done_o(pd_a), .word_done_o(wd_a)
  );

  bit_phase_sequencer #(.WIDTH(5), .PHASES(3)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .stall_i(stall), .abort_i(abort),
    .msb_first_i(msb_first), .phase_mask_i(mask_b), .ready_o(ready_b), .busy_o(busy_b),
    .bit_idx_o(idx_b), .phase_o(ph_b), .bit_valid_o(bv_b), .first_bit_o(fb_b),
    .last_bit_o(lb_b), .phase_done_o(pd_b), .word_done_o(wd_b)
  );

  logic       sel_b;
  logic       o_ready, o_busy, o_vld, o_first, o_last, o_pd, o_wd;
  logic [2:0] o_idx;
  logic [1:0] o_ph;

  always_comb begin
    if (sel_b) begin
      {o_ready, o_busy, o_vld, o_first, o_last, o_pd, o_wd} = {ready_b, busy_b, bv_b, fb_b, lb_b, pd_b, wd_b};
      o_idx = idx_b;
      o_ph  = ph_b;
    end else begin
      {o_ready, o_busy, o_vld, o_first, o_last, o_pd, o_wd} = {ready_a, busy_a, bv_a, fb_a, lb_a, pd_a, wd_a};
      o_idx = idx_a;
      o_ph  = ph_a;
    end
  end

  typedef struct packed {
    logic       drv_start, drv_stall, drv_abort, drv_msb;
    logic [3:0] drv_mask;
    logic       run, vld;
    logic [2:0] idx;
    logic [1:0] ph;
    logic       first, last, pdone, wdone;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: expands one word into per-cycle records.
  task automatic push_word(input int w, input logic [3:0] mask, input logic msb, input bit accept,
                           input int stall_at, input int stall_len, input int abort_at,
                           input bit b2b, input logic [3:0] nmask, input logic nmsb);
    rec_t r;
    int   ord;
    bit   pend;
    ord  = 0;
    pend = 1'b0;
    if (accept) begin
      r = '0; r.drv_start = 1'b1; r.drv_mask = mask; r.drv_msb = msb;
      sb.push_back(r);
    end
    for (int p = 0; p < 4; p++) begin
      if (!mask[p]) continue;
      for (int c = 0; c < w; c++) begin
        if (ord == stall_at) begin
          for (int s = 0; s < stall_len; s++) begin
            r = '0; r.drv_stall = 1'b1; r.run = 1'b1;
            r.idx = msb ? 3'(w - 1 - c) : 3'(c); r.ph = 2'(p); r.pdone = pend;
            pend = 1'b0;
            sb.push_back(r);
          end
        end
        r = '0; r.run = 1'b1; r.vld = 1'b1;
        r.idx = msb ? 3'(w - 1 - c) : 3'(c); r.ph = 2'(p);
        r.first = (c == 0); r.last = (c == w - 1); r.pdone = pend;
        pend = 1'b0;
        if (ord == abort_at) begin
          r.drv_abort = 1'b1;
          sb.push_back(r);
          r = '0;
          sb.push_back(r);
          return;
        end
        sb.push_back(r);
        pend = (c == w - 1);
        ord++;
      end
    end
    r = '0; r.pdone = pend; r.wdone = 1'b1;
    r.drv_start = b2b; r.drv_mask = nmask; r.drv_msb = nmsb;
    sb.push_back(r);
  endtask

  // Scoreboard consumer: drive one record per cycle and compare the outputs it predicts.
  task automatic drain(input int max_n);
    rec_t       r;
    logic [11:0] act, exp_v;
    int         n;
    n = 0;
    while (sb.size() > 0 && n < max_n) begin
      @(posedge clk); #1;
      r = sb.pop_front();
      if (sel_b) begin start_b = r.drv_start; mask_b = r.drv_mask[2:0]; end
      else       begin start_a = r.drv_start; mask_a = r.drv_mask;      end
      msb_first = r.drv_msb; stall = r.drv_stall; abort = r.drv_abort;
      #3;
      act   = {o_busy, o_ready, o_vld, o_idx, o_ph, o_first, o_last, o_pd, o_wd};
      exp_v = {r.run, !r.run, r.vld, r.idx, r.ph, r.first, r.last, r.pdone, r.wdone};
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL cycle_%0d dut_%s busy/rdy/vld/idx/ph/first/last/pd/wd got %b want %b",
                 cyc, sel_b ? "b" : "a", act, exp_v);
      end
      if (sel_b) begin
        n_cmp++;
        if (o_idx > 3'd4) begin
          n_err++;
          $display("FAIL idx_range_b got %0d want <=4", o_idx);
        end
      end
      n++;
      cyc++;
    end
    #0;
    start_a = 1'b0; start_b = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; stall = 1'b0; abort = 1'b0;
    msb_first = 1'b0; mask_a = '0; mask_b = '0; sel_b = 1'b0;
    #12;
    n_cmp++;
    if ({ready_a, busy_a, bv_a, fb_a, lb_a, pd_a, wd_a, idx_a, ph_a} !== {7'b1000000, 3'd0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_a got %b want %b", {ready_a, busy_a, bv_a, fb_a, lb_a, pd_a, wd_a, idx_a, ph_a}, 12'b100000000000);
    end
    n_cmp++;
    if ({ready_b, busy_b, bv_b, fb_b, lb_b, pd_b, wd_b, idx_b, ph_b} !== {7'b1000000, 3'd0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_b got %b want %b", {ready_b, busy_b, bv_b, fb_b, lb_b, pd_b, wd_b, idx_b, ph_b}, 12'b100000000000);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_async_reset_midrun();
    sel_b = 1'b0;
    push_word(8, 4'b1111, 1'b0, 1'b1, -1, 0, -1, 1'b0, 4'b0, 1'b0);
    drain(21);
    @(posedge clk); #1;
    n_cmp++;
    if ({ph_a, idx_a, busy_a} !== {2'd2, 3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL midrun_pos ph/idx/busy got %b want %b", {ph_a, idx_a, busy_a}, 6'b101001);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({ready_a, busy_a, bv_a, idx_a, ph_a, pd_a, wd_a} !== {3'b100, 3'd0, 2'd0, 2'b00}) begin
      n_err++;
      $display("FAIL async_reset got %b want %b", {ready_a, busy_a, bv_a, idx_a, ph_a, pd_a, wd_a}, 10'b1000000000);
    end
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_lsb_all_phases();
    sel_b = 1'b0;
    push_word(8, 4'b1111, 1'b0, 1'b1, -1, 0, -1, 1'b0, 4'b0, 1'b0);
    drain(1000);
  endtask

  task automatic test_msb_sparse();
    sel_b = 1'b0;
    push_word(8, 4'b0101, 1'b1, 1'b1, -1, 0, -1, 1'b0, 4'b0, 1'b0);
    drain(1000);
  endtask

  task automatic test_stall();
    sel_b = 1'b0;
    push_word(8, 4'b1111, 1'b0, 1'b1, 13, 3, -1, 1'b0, 4'b0, 1'b0);
    drain(1000);
  endtask

  task automatic test_abort_and_empty();
    sel_b = 1'b0;
    push_word(8, 4'b1111, 1'b0, 1'b1, -1, 0, 19, 1'b0, 4'b0, 1'b0);
    drain(1000);
    push_word(8, 4'b0000, 1'b0, 1'b1, -1, 0, -1, 1'b0, 4'b0, 1'b0);
    drain(1000);
    @(posedge clk); #4;
    n_cmp++;
    if ({busy_a, ready_a, wd_a} !== 3'b010) begin
      n_err++;
      $display("FAIL empty_after busy/rdy/wd got %b want 010", {busy_a, ready_a, wd_a});
    end
  endtask

  task automatic test_back_to_back();
    sel_b = 1'b1;
    push_word(5, 4'b0111, 1'b0, 1'b1, -1, 0, -1, 1'b1, 4'b0111, 1'b1);
    push_word(5, 4'b0111, 1'b1, 1'b0, -1, 0, -1, 1'b0, 4'b0, 1'b0);
    drain(1000);
  endtask

  initial begin
    test_reset();
    test_async_reset_midrun();
    test_lsb_all_phases();
    test_msb_sparse();
    test_stall();
    test_abort_and_empty();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
